// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants and state encoding for the data-memory port arbiter.
// No logic, no latency.
// Not applicable: the package has no ports and applies no backpressure.
package dmem_port_arbiter_pkg;

  // Word load and store opcodes presented to data_memory
  localparam logic [5:0] LW_OPCODE = 6'h23;
  localparam logic [5:0] SW_OPCODE = 6'h2b;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_WAIT  = 2'd1,
    DMA_STALL = 2'd2,
    DMA_RESP  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the MEM stage (priority) and the debug unit.
// Debug access is granted at least 1 cycle after the request is latched; ack follows 1 cycle later.
// The pipeline is never blocked, except for a single forced stall cycle after MAX_WAIT busy cycles.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halted_in,
  input  logic        pipe_mem_read_in,
  input  logic        pipe_mem_write_in,
  input  logic [31:0] pipe_address_in,
  input  logic [31:0] pipe_write_data_in,
  input  logic [5:0]  pipe_opcode_in,
  output logic [31:0] pipe_read_data_out,
  output logic        pipe_stall_out,
  input  logic        dbg_req_in,
  input  logic        dbg_we_in,
  input  logic [31:0] dbg_address_in,
  input  logic [31:0] dbg_write_data_in,
  output logic        dbg_ack_out,
  output logic [31:0] dbg_read_data_out,
  output logic [31:0] mem_address_out,
  output logic [31:0] mem_write_data_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [5:0]  mem_opcode_out,
  input  logic [31:0] mem_read_data_in
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  dma_state_t        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              lat_we;
  logic [31:0]       lat_address;
  logic [31:0]       lat_write_data;
  logic              slot_free;
  logic              dbg_owns;

  // A halted pipeline no longer uses memory, so its stuck request lines do not block debug
  assign slot_free = halted_in | ~(pipe_mem_read_in | pipe_mem_write_in);

  // Debug owns the port on its grant cycle; reset revokes ownership so no stray write escapes
  assign dbg_owns = ~reset & (((state == DMA_WAIT) & slot_free) | (state == DMA_STALL));

  assign pipe_stall_out     = (state == DMA_STALL);
  assign pipe_read_data_out = mem_read_data_in;

  // Memory port mux: latched debug fields on the grant cycle, pipeline pass-through otherwise
  always_comb begin
    mem_address_out    = pipe_address_in;
    mem_write_data_out = pipe_write_data_in;
    mem_opcode_out     = pipe_opcode_in;
    mem_read_out       = pipe_mem_read_in;
    mem_write_out      = pipe_mem_write_in & ~reset;
    if (dbg_owns) begin
      mem_address_out    = lat_address;
      mem_write_data_out = lat_write_data;
      mem_opcode_out     = lat_we ? SW_OPCODE : LW_OPCODE;
      mem_read_out       = ~lat_we;
      mem_write_out      = lat_we;
    end
  end

  // Arbitration FSM with inline wait counter, request latches and registered ack/read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= DMA_IDLE;
      wait_cnt          <= '0;
      lat_we            <= 1'b0;
      lat_address       <= 32'h0;
      lat_write_data    <= 32'h0;
      dbg_ack_out       <= 1'b0;
      dbg_read_data_out <= 32'h0;
    end else begin
      dbg_ack_out <= 1'b0;
      case (state)
        DMA_IDLE: begin
          if (dbg_req_in) begin
            lat_we         <= dbg_we_in;
            lat_address    <= {dbg_address_in[31:2], 2'b00};
            lat_write_data <= dbg_write_data_in;
            wait_cnt       <= '0;
            state          <= DMA_WAIT;
          end
        end
        DMA_WAIT: begin
          if (slot_free) begin
            if (!lat_we) dbg_read_data_out <= mem_read_data_in;
            dbg_ack_out <= 1'b1;
            state       <= DMA_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            state <= DMA_STALL;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DMA_STALL: begin
          if (!lat_we) dbg_read_data_out <= mem_read_data_in;
          dbg_ack_out <= 1'b1;
          state       <= DMA_RESP;
        end
        DMA_RESP: begin
          state <= DMA_IDLE;
        end
        default: state <= DMA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized scoreboard bench for dmem_port_arbiter with a simple data memory attached.
// Expectations are pushed per cycle by the driver; a negedge monitor pops and compares.
// The debug requester holds its request until ack; the pipeline replays any access lost to a stall.
module tb_dmem_port_arbiter;

  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 5;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;

  logic        clk = 1'b0;
  logic        reset;
  logic        halted_in;
  logic        pipe_mem_read_in, pipe_mem_write_in;
  logic [31:0] pipe_address_in, pipe_write_data_in;
  logic [5:0]  pipe_opcode_in;
  logic [31:0] pipe_read_data_out;
  logic        pipe_stall_out;
  logic        dbg_req_in, dbg_we_in;
  logic [31:0] dbg_address_in, dbg_write_data_in;
  logic        dbg_ack_out;
  logic [31:0] dbg_read_data_out;
  logic [31:0] mem_address_out, mem_write_data_out;
  logic        mem_read_out, mem_write_out;
  logic [5:0]  mem_opcode_out;
  logic [31:0] mem_read_data_in;

  dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .halted_in(halted_in),
    .pipe_mem_read_in(pipe_mem_read_in), .pipe_mem_write_in(pipe_mem_write_in),
    .pipe_address_in(pipe_address_in), .pipe_write_data_in(pipe_write_data_in),
    .pipe_opcode_in(pipe_opcode_in), .pipe_read_data_out(pipe_read_data_out),
    .pipe_stall_out(pipe_stall_out),
    .dbg_req_in(dbg_req_in), .dbg_we_in(dbg_we_in), .dbg_address_in(dbg_address_in),
    .dbg_write_data_in(dbg_write_data_in), .dbg_ack_out(dbg_ack_out),
    .dbg_read_data_out(dbg_read_data_out),
    .mem_address_out(mem_address_out), .mem_write_data_out(mem_write_data_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_opcode_out(mem_opcode_out), .mem_read_data_in(mem_read_data_in)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i) * 32'h0101);
  endfunction

  // Data memory: combinational read, write on the clock edge; loaded on the first edge
  logic [31:0] env_mem [0:63];
  logic        env_loaded = 1'b0;
  always @(posedge clk) begin
    if (!env_loaded) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= init_word(i);
      env_loaded <= 1'b1;
    end else if (mem_write_out) begin
      env_mem[mem_address_out[7:2]] <= mem_write_data_out;
    end
  end
  assign mem_read_data_in = env_mem[mem_address_out[7:2]];

  typedef struct {
    int          cyc;
    bit          dbg;
    logic [31:0] addr;
    logic [5:0]  opc;
    bit          rd;
    bit          wr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] rd_exp;
    bit          stall;
  } port_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } ack_exp_t;

  port_exp_t pq[$];
  ack_exp_t  aq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: architectural memory plus the one outstanding debug request
  logic [31:0] ref_mem [0:63];
  bit          active, granted, rep;
  int          start, g;
  bit          m_we;
  logic [31:0] m_addr, m_wd, exp_rdata;
  bit          s_rd, s_wr;
  logic [31:0] s_pa, s_pd;
  logic [5:0]  s_po;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the model decides who owns memory and what must be observed
  task automatic step(input bit want_req, input logic [31:0] da, input bit dwe,
                      input logic [31:0] dwd, input int busy_pct, input bit halt,
                      input bit rst, input int paddr);
    port_exp_t e;
    ack_exp_t  a;
    bit rd, wr, free, grant, stall;
    logic [31:0] pa, pd;
    logic [5:0]  po;
    @(posedge clk);
    #1;
    cyc++;
    reset = rst;

    if (rst) begin
      active = 0; granted = 0; dbg_req_in = 1'b0;
    end else if (active && granted && cyc == g + 1) begin
      dbg_req_in = 1'b1;
      active = 0;
    end else if (!active) begin
      if (want_req) begin
        active = 1; granted = 0; start = cyc;
        m_we = dwe; m_addr = {da[31:2], 2'b00}; m_wd = dwd;
        dbg_req_in = 1'b1; dbg_we_in = dwe; dbg_address_in = da; dbg_write_data_in = dwd;
      end else begin
        dbg_req_in = 1'b0; dbg_we_in = 1'($urandom_range(0, 1));
        dbg_address_in = $urandom; dbg_write_data_in = $urandom;
      end
    end else begin
      dbg_req_in = 1'b1;
    end

    if (rst) begin
      rd = 0; wr = 0; pa = 32'h0; pd = 32'h0; po = 6'h0;
    end else if (rep) begin
      rd = s_rd; wr = s_wr; pa = s_pa; pd = s_pd; po = s_po;
    end else begin
      pa = 32'($urandom_range(0, 63)) << 2;
      pd = $urandom;
      rd = 0; wr = 0;
      if (paddr >= 0) begin rd = 1; pa = 32'(paddr); end
      else if (halt) begin rd = 1; wr = 1; end
      else if (int'($urandom_range(0, 99)) < busy_pct) begin
        if ($urandom_range(0, 1) == 1) rd = 1; else wr = 1;
      end
      po = rd ? OP_LW : (wr ? OP_SW : 6'($urandom_range(0, 63)));
    end
    rep = 0;
    halted_in = halt && !rst;
    pipe_mem_read_in = rd; pipe_mem_write_in = wr;
    pipe_address_in = pa; pipe_write_data_in = pd; pipe_opcode_in = po;

    free  = (halt && !rst) || (!rd && !wr);
    grant = !rst && active && !granted && cyc >= start + 1 &&
            (free || cyc == start + 1 + MAX_WAIT);
    stall = grant && (cyc == start + 1 + MAX_WAIT);

    e.cyc = cyc; e.dbg = grant; e.stall = stall; e.chk_rd = 0; e.rd_exp = 32'h0;
    if (grant) begin
      e.addr = m_addr; e.opc = m_we ? OP_SW : OP_LW;
      e.rd = !m_we; e.wr = m_we; e.wdata = m_wd;
      granted = 1; g = cyc;
      if (m_we) ref_mem[m_addr[7:2]] = m_wd;
      else exp_rdata = ref_mem[m_addr[7:2]];
      a.cyc = cyc + 1; a.data = exp_rdata;
      aq.push_back(a);
      if (stall && (rd || wr)) begin
        rep = 1; s_rd = rd; s_wr = wr; s_pa = pa; s_pd = pd; s_po = po;
      end
    end else begin
      e.addr = pa; e.opc = po; e.rd = rd; e.wr = wr; e.wdata = pd;
      e.chk_rd = rd; e.rd_exp = ref_mem[pa[7:2]];
      if (wr) ref_mem[pa[7:2]] = pd;
    end
    if (rst) begin
      exp_rdata = 32'h0;
      aq.delete();
    end
    pq.push_back(e);
  endtask

  task automatic idle(input int n, input int busy);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0, 32'h0, busy, 0, 0, -1);
  endtask

  // Monitor: compares the memory port each cycle and every debug acknowledge
  port_exp_t m_e;
  ack_exp_t  m_a;
  always @(negedge clk) begin
    if (pq.size() > 0 && pq[0].cyc == cyc) begin
      m_e = pq.pop_front();
      chk("stall", {31'h0, pipe_stall_out}, {31'h0, m_e.stall});
      chk(m_e.dbg ? "dbg_mem_addr" : "pipe_mem_addr", mem_address_out, m_e.addr);
      chk("mem_opcode", {26'h0, mem_opcode_out}, {26'h0, m_e.opc});
      chk("mem_read", {31'h0, mem_read_out}, {31'h0, m_e.rd});
      chk("mem_write", {31'h0, mem_write_out}, {31'h0, m_e.wr});
      if (m_e.wr) chk("mem_wdata", mem_write_data_out, m_e.wdata);
      if (m_e.chk_rd) chk("pipe_rdata", pipe_read_data_out, m_e.rd_exp);
    end
    if (dbg_ack_out === 1'b1) begin
      if (aq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        m_a = aq.pop_front();
        chk("ack_cycle", 32'(cyc), 32'(m_a.cyc));
        chk("dbg_rdata", dbg_read_data_out, m_a.data);
      end
    end else if (aq.size() > 0 && aq[0].cyc <= cyc) begin
      m_a = aq.pop_front();
      checks++; errors++;
      $display("FAIL missing_ack: got no ack expected one at cycle %0d", m_a.cyc);
    end
  end

  initial begin
    int busy;
    bit halt;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    active = 0; granted = 0; rep = 0; exp_rdata = 32'h0; start = 0; g = 0;
    reset = 1'b1; halted_in = 1'b0;
    pipe_mem_read_in = 1'b0; pipe_mem_write_in = 1'b0;
    pipe_address_in = 32'h0; pipe_write_data_in = 32'h0; pipe_opcode_in = 6'h0;
    dbg_req_in = 1'b0; dbg_we_in = 1'b0; dbg_address_in = 32'h0; dbg_write_data_in = 32'h0;

    for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 32'h0, 0, 0, 1, -1);
    @(negedge clk);
    chk("reset_ack", {31'h0, dbg_ack_out}, 32'h0);
    chk("reset_stall", {31'h0, pipe_stall_out}, 32'h0);
    chk("reset_dbg_rdata", dbg_read_data_out, 32'h0);

    // Idle pipeline, debug read of 0x10
    step(1, 32'h10, 0, 32'h0, 0, 0, 0, -1);
    idle(4, 0);
    // Debug write to 0x20 then a pipeline load of 0x20
    step(1, 32'h20, 1, 32'h12345678, 0, 0, 0, -1);
    idle(3, 0);
    step(0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h20);
    idle(2, 0);
    // Continuous loads force the stall slot
    step(1, 32'h10, 0, 32'h0, 100, 0, 0, -1);
    for (int i = 0; i < 20; i++) step(0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h20);
    idle(3, 0);
    // Halted with stuck request lines, unaligned debug write then read
    step(1, 32'h23, 1, 32'hA5A5_0F0F, 0, 1, 0, -1);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 32'h0, 0, 1, 0, -1);
    step(1, 32'h22, 0, 32'h0, 0, 1, 0, -1);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 32'h0, 0, 1, 0, -1);
    idle(3, 0);

    // Randomized phases of pipeline load, halt periods and debug traffic
    for (int ph = 0; ph < 15; ph++) begin
      busy = int'($urandom_range(0, 100));
      halt = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 2) == 0, 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             $urandom, busy, halt, 0, -1);
    end
    idle(25, 0);

    // Reset while a debug write waits behind a busy pipeline
    step(1, 32'h40, 1, 32'hCAFEF00D, 100, 0, 0, -1);
    idle(4, 100);
    step(0, 32'h0, 0, 32'h0, 0, 0, 1, -1);
    step(0, 32'h0, 0, 32'h0, 0, 0, 0, -1);
    @(negedge clk);
    chk("post_reset_ack", {31'h0, dbg_ack_out}, 32'h0);
    chk("post_reset_stall", {31'h0, pipe_stall_out}, 32'h0);
    chk("post_reset_dbg_rdata", dbg_read_data_out, 32'h0);
    idle(25, 50);

    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 64; i++) chk("final_mem", env_mem[i], ref_mem[i]);
    chk("port_queue_drained", 32'(pq.size()), 32'h0);
    chk("ack_queue_drained", 32'(aq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
